// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the ctrl_seq fetch/execute sequencer.
// Optional HALT opcode support is enabled by defining CTRL_SEQ_HALT_EN.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_IMM     = 3'd2,
        ST_ALU_SET = 3'd3,
        ST_ALU_WB  = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [1:0] CLS_MOV  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_ALU  = 2'b10;
    localparam logic [1:0] CLS_MISC = 2'b11;

    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
    localparam int REG_D = 3;

    localparam int AR_PCRA0 = 0;
    localparam int AR_PCRA1 = 1;
    localparam int AR_SP    = 2;
    localparam int AR_SI    = 3;
    localparam int AR_DI    = 4;

    localparam int N_GP = 4;
    localparam int N_AR = 5;

    function automatic logic [N_GP-1:0] gp_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational opcode decode: IR -> class, register indices, ALU op, HALT/NOP flags.
// 0xFF is recognised as HALT only when CTRL_SEQ_HALT_EN is defined.
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
(
    input  logic [7:0] i_ir,
    output logic [1:0] o_cls,
    output logic [1:0] o_src,
    output logic [1:0] o_dst,
    output logic [3:0] o_alu_op,
    output logic       o_is_halt,
    output logic       o_is_nop
);

    logic w_halt_code;

`ifdef CTRL_SEQ_HALT_EN
    assign w_halt_code = (i_ir == OP_HALT);
`else
    assign w_halt_code = 1'b0;
`endif

    // NOTE: every output gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        o_cls     = i_ir[7:6];
        o_src     = i_ir[1:0];
        o_dst     = i_ir[1:0];
        o_alu_op  = i_ir[5:2];
        o_is_halt = 1'b0;
        o_is_nop  = 1'b0;

        unique case (i_ir[7:6])
            CLS_MOV: begin
                o_dst    = i_ir[3:2];
                o_is_nop = (i_ir[5:4] != 2'b00);
            end
            CLS_LDI, CLS_ALU: ;
            CLS_MISC: begin
                o_is_halt = w_halt_code;
                o_is_nop  = ~w_halt_code;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/execute sequencer driving the GP/address register strobes and ALU op select.
// Define CTRL_SEQ_HALT_EN to make 0xFF stop the sequencer and raise halted.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int WIDTH_MAIN = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH_MAIN-1:0] main_in,
    input  logic                  mem_ready,
    output logic                  mem_read,
    output logic [3:0]            gp_assert_main,
    output logic [3:0]            gp_load_main,
    output logic [3:0]            gp_assert_lhs,
    output logic [3:0]            gp_assert_rhs,
    output logic [4:0]            ar_assert_addr,
    output logic [4:0]            ar_inc,
    output logic                  alu_assert_main,
    output logic [3:0]            alu_operation,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count
);

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH_MAIN-1:0] r_ir;
    logic [CNT_W-1:0]      r_count;

    logic [1:0] w_cls;
    logic [1:0] w_src;
    logic [1:0] w_dst;
    logic [3:0] w_alu_op;
    logic       w_is_halt;
    logic       w_is_nop;
    logic       w_is_mov;
    logic       w_retire;
    logic       w_ir_load;

    ctrl_seq_decode u_decode (
        .i_ir      (r_ir[7:0]),
        .o_cls     (w_cls),
        .o_src     (w_src),
        .o_dst     (w_dst),
        .o_alu_op  (w_alu_op),
        .o_is_halt (w_is_halt),
        .o_is_nop  (w_is_nop)
    );

    assign w_is_mov = (w_cls == CLS_MOV) && !w_is_nop;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_FETCH: if (mem_ready) w_next = ST_EXEC;
            ST_EXEC: begin
                if (w_is_halt) begin
                    w_next = ST_HALT;
                end else if (w_is_nop) begin
                    w_next = ST_FETCH;
                end else begin
                    unique case (w_cls)
                        CLS_LDI: w_next = ST_IMM;
                        CLS_ALU: w_next = ST_ALU_SET;
                        default: w_next = ST_FETCH;
                    endcase
                end
            end
            ST_IMM:     if (mem_ready) w_next = ST_FETCH;
            ST_ALU_SET: w_next = ST_ALU_WB;
            ST_ALU_WB:  w_next = ST_FETCH;
            ST_HALT:    w_next = ST_HALT;
            default:    w_next = ST_FETCH;
        endcase
    end

    // An instruction retires on its final edge back to FETCH, or on entering HALT.
    assign w_retire = !reset &&
        (((w_next == ST_FETCH) &&
          ((r_state == ST_EXEC) || (r_state == ST_IMM) || (r_state == ST_ALU_WB))) ||
         ((w_next == ST_HALT) && (r_state != ST_HALT)));

    assign w_ir_load = (r_state == ST_FETCH) && mem_ready;

    // NOTE: IR and counter are plain registers, so they get an explicit reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            if (w_ir_load) r_ir <= main_in;
            if (w_retire)  r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        ar_assert_addr  = '0;
        ar_inc          = '0;
        gp_assert_main  = '0;
        gp_load_main    = '0;
        gp_assert_lhs   = '0;
        gp_assert_rhs   = '0;
        alu_assert_main = 1'b0;
        alu_operation   = '0;

        if (!reset) begin
            unique case (r_state)
                ST_FETCH: begin
                    mem_read                 = 1'b1;
                    ar_assert_addr[AR_PCRA0] = 1'b1;
                    ar_inc[AR_PCRA0]         = mem_ready;
                end
                ST_EXEC: begin
                    if (w_is_mov) begin
                        gp_assert_main = gp_onehot(w_src);
                        gp_load_main   = gp_onehot(w_dst);
                    end
                end
                ST_IMM: begin
                    mem_read                 = 1'b1;
                    ar_assert_addr[AR_PCRA0] = 1'b1;
                    ar_inc[AR_PCRA0]         = mem_ready;
                    if (mem_ready) gp_load_main = gp_onehot(w_dst);
                end
                ST_ALU_SET: begin
                    gp_assert_lhs[REG_A] = 1'b1;
                    gp_assert_rhs[REG_B] = 1'b1;
                    alu_operation        = w_alu_op;
                end
                ST_ALU_WB: begin
                    gp_assert_lhs[REG_A] = 1'b1;
                    gp_assert_rhs[REG_B] = 1'b1;
                    alu_operation        = w_alu_op;
                    alu_assert_main      = 1'b1;
                    gp_load_main         = gp_onehot(w_dst);
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_SEQ_HALT_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    assign instr_count = r_count;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: per-cycle strobe traces queued from an opcode table.
// Expectations for 0xFF follow CTRL_SEQ_HALT_EN as defined for the build.
module tb_ctrl_seq;

    localparam int TB_CNT_W = 10;  // narrow counter so the wrap is reachable in ~2k cycles

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          main_in;
    logic                mem_ready;
    logic                mem_read;
    logic [3:0]          gp_assert_main, gp_load_main, gp_assert_lhs, gp_assert_rhs;
    logic [4:0]          ar_assert_addr, ar_inc;
    logic                alu_assert_main;
    logic [3:0]          alu_operation;
    logic                halted;
    logic [TB_CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    ctrl_seq #(.WIDTH_MAIN(8), .CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .main_in         (main_in),
        .mem_ready       (mem_ready),
        .mem_read        (mem_read),
        .gp_assert_main  (gp_assert_main),
        .gp_load_main    (gp_load_main),
        .gp_assert_lhs   (gp_assert_lhs),
        .gp_assert_rhs   (gp_assert_rhs),
        .ar_assert_addr  (ar_assert_addr),
        .ar_inc          (ar_inc),
        .alu_assert_main (alu_assert_main),
        .alu_operation   (alu_operation),
        .halted          (halted),
        .instr_count     (instr_count)
    );

    typedef struct packed {
        logic       mem_read;
        logic [4:0] ar_addr;
        logic [4:0] ar_inc;
        logic [3:0] gp_am;
        logic [3:0] gp_lm;
        logic [3:0] gp_lhs;
        logic [3:0] gp_rhs;
        logic       alu_am;
        logic [3:0] alu_op;
        logic       halted;
    } out_t;

    typedef struct {
        logic                rdy;
        logic [7:0]          bus;
        out_t                exp;
        logic [TB_CNT_W-1:0] cnt;
        int                  tag;
    } cyc_t;

    typedef enum {K_MOV, K_NOP, K_LDI, K_ALU, K_HALT} kind_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] imm;
        int         fw;
        int         iw;
        logic       rdy_else;
        kind_t      kind;
        logic [3:0] src_m;
        logic [3:0] dst_m;
        logic [3:0] aop;
    } vec_t;

    int                  n_checks = 0;
    int                  n_errors = 0;
    cyc_t                q[$];
    logic [TB_CNT_W-1:0] exp_cnt;
    vec_t                vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t get_out();
        out_t o;
        o.mem_read = mem_read;
        o.ar_addr  = ar_assert_addr;
        o.ar_inc   = ar_inc;
        o.gp_am    = gp_assert_main;
        o.gp_lm    = gp_load_main;
        o.gp_lhs   = gp_assert_lhs;
        o.gp_rhs   = gp_assert_rhs;
        o.alu_am   = alu_assert_main;
        o.alu_op   = alu_operation;
        o.halted   = halted;
        return o;
    endfunction

    function automatic out_t o_mem(input logic inc, input logic [3:0] lm);
        out_t o = '0;
        o.mem_read = 1'b1;
        o.ar_addr  = 5'b00001;
        o.ar_inc   = {4'b0000, inc};
        o.gp_lm    = lm;
        return o;
    endfunction

    function automatic out_t o_alu(input logic [3:0] aop, input logic wb, input logic [3:0] lm);
        out_t o = '0;
        o.gp_lhs = 4'b0001;
        o.gp_rhs = 4'b0010;
        o.alu_op = aop;
        o.alu_am = wb;
        o.gp_lm  = wb ? lm : 4'b0000;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic [7:0] bus, input out_t e, input int tag);
        cyc_t c;
        c.rdy = rdy;
        c.bus = bus;
        c.exp = e;
        c.cnt = exp_cnt;
        c.tag = tag;
        q.push_back(c);
    endtask

    task automatic build(input vec_t v, input int tag);
        out_t o;
        for (int i = 0; i < v.fw; i++) push(1'b0, 8'h00, o_mem(1'b0, 4'b0000), tag);
        push(1'b1, v.op, o_mem(1'b1, 4'b0000), tag);
        case (v.kind)
            K_MOV: begin
                o = '0;
                o.gp_am = v.src_m;
                o.gp_lm = v.dst_m;
                push(v.rdy_else, 8'h00, o, tag);
            end
            K_NOP: push(v.rdy_else, 8'h00, '0, tag);
            K_LDI: begin
                push(v.rdy_else, 8'h00, '0, tag);
                for (int i = 0; i < v.iw; i++) push(1'b0, 8'h00, o_mem(1'b0, 4'b0000), tag);
                push(1'b1, v.imm, o_mem(1'b1, v.dst_m), tag);
            end
            K_ALU: begin
                push(v.rdy_else, 8'h00, '0, tag);
                push(v.rdy_else, 8'h00, o_alu(v.aop, 1'b0, v.dst_m), tag);
                push(v.rdy_else, 8'h00, o_alu(v.aop, 1'b1, v.dst_m), tag);
            end
            default: begin
                push(v.rdy_else, 8'h00, '0, tag);
                exp_cnt++;
                o = '0;
                o.halted = 1'b1;
                for (int i = 0; i < 3; i++) push(1'b1, 8'h09, o, tag);
                exp_cnt--;
            end
        endcase
        exp_cnt++;
    endtask

    // Starts just after a rising edge; leaves off just after a rising edge.
    task automatic run_queue();
        cyc_t c;
        int   k = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            main_in   = c.bus;
            @(negedge clk);
            check($sformatf("v%0d.c%0d strobes", c.tag, k), 64'(get_out()), 64'(c.exp));
            check($sformatf("v%0d.c%0d instr_count", c.tag, k), 64'(instr_count), 64'(c.cnt));
            k++;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0)
            check("bus_one_driver",
                  64'(($countones(gp_assert_main) + int'(alu_assert_main) + int'(mem_read & mem_ready)) <= 1),
                  64'd1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t extra;

        vecs[0]  = '{8'h09, 8'h00, 0, 0, 1'b0, K_MOV, 4'b0010, 4'b0100, 4'h0};
        vecs[1]  = '{8'h43, 8'h5A, 0, 2, 1'b0, K_LDI, 4'b0000, 4'b1000, 4'h0};
        vecs[2]  = '{8'h86, 8'h00, 0, 0, 1'b0, K_ALU, 4'b0000, 4'b0100, 4'h1};
        vecs[3]  = '{8'h00, 8'h00, 1, 0, 1'b0, K_MOV, 4'b0001, 4'b0001, 4'h0};
        vecs[4]  = '{8'h0F, 8'h00, 0, 0, 1'b1, K_MOV, 4'b1000, 4'b1000, 4'h0};
        vecs[5]  = '{8'h1B, 8'h00, 0, 0, 1'b0, K_NOP, 4'b0000, 4'b0000, 4'h0};
        vecs[6]  = '{8'hC3, 8'h00, 2, 0, 1'b1, K_NOP, 4'b0000, 4'b0000, 4'h0};
        vecs[7]  = '{8'h4E, 8'hA5, 1, 0, 1'b1, K_LDI, 4'b0000, 4'b0100, 4'h0};
        vecs[8]  = '{8'hBF, 8'h00, 0, 0, 1'b0, K_ALU, 4'b0000, 4'b1000, 4'hF};
        vecs[9]  = '{8'h24, 8'h00, 0, 0, 1'b0, K_NOP, 4'b0000, 4'b0000, 4'h0};
        vecs[10] = '{8'h06, 8'h00, 3, 0, 1'b1, K_MOV, 4'b0100, 4'b0010, 4'h0};
        vecs[11] = '{8'h81, 8'h00, 0, 0, 1'b1, K_ALU, 4'b0000, 4'b0010, 4'h0};
        vecs[12] = '{8'hFE, 8'h00, 0, 0, 1'b0, K_NOP, 4'b0000, 4'b0000, 4'h0};
`ifdef CTRL_SEQ_HALT_EN
        vecs[13] = '{8'hFF, 8'h00, 0, 0, 1'b1, K_HALT, 4'b0000, 4'b0000, 4'h0};
`else
        vecs[13] = '{8'hFF, 8'h00, 0, 0, 1'b1, K_NOP, 4'b0000, 4'b0000, 4'h0};
`endif

        // Reset: strobes stay low even with memory claiming ready.
        reset     = 1'b1;
        mem_ready = 1'b1;
        main_in   = 8'h09;
        @(posedge clk);
        @(negedge clk);
        check("reset strobes", 64'(get_out()), 64'd0);
        check("reset instr_count", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        exp_cnt = '0;
        for (int i = 0; i < 14; i++) build(vecs[i], i);
`ifndef CTRL_SEQ_HALT_EN
        extra = '{8'h09, 8'h00, 0, 0, 1'b0, K_MOV, 4'b0010, 4'b0100, 4'h0};
        build(extra, 14);
`endif
        run_queue();

        // Reset abandons an LDI waiting on its immediate.
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = '0;
        build(vecs[0], 20);
        push(1'b1, 8'h41, o_mem(1'b1, 4'b0000), 21);
        push(1'b0, 8'h00, '0, 21);
        push(1'b0, 8'h00, o_mem(1'b0, 4'b0000), 21);
        run_queue();
        reset     = 1'b1;
        mem_ready = 1'b1;
        main_in   = 8'h77;
        @(negedge clk);
        check("rst_imm strobes", 64'(get_out()), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("post_reset fetch", 64'(get_out()), 64'(o_mem(1'b0, 4'b0000)));
        check("post_reset instr_count", 64'(instr_count), 64'd0);

        // Counter wrap: back-to-back zero-wait NOPs, two cycles each.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b1;
        main_in   = 8'hC0;
        repeat (2 * ((1 << TB_CNT_W) - 1)) @(posedge clk);
        #1;
        check("wrap pre", 64'(instr_count), 64'((1 << TB_CNT_W) - 1));
        repeat (2) @(posedge clk);
        #1;
        check("wrap post", 64'(instr_count), 64'd0);
        mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
